// File: rtl/alu_pkg.sv
// Operation codes understood by the 8-bit byte alu.
package alu_pkg;

    localparam logic [2:0] ALU_OP_SUM  = 3'd0;
    localparam logic [2:0] ALU_OP_AND  = 3'd1;
    localparam logic [2:0] ALU_OP_OR   = 3'd2;
    localparam logic [2:0] ALU_OP_XOR  = 3'd3;
    localparam logic [2:0] ALU_OP_TEST = 3'd7;

endpackage

// File: rtl/alu_word_seq_pkg.sv
// Shared types for the word sequencer: word-level operation codes and FSM states.
package alu_word_seq_pkg;

    typedef enum logic [2:0] {
        WSEQ_ADD  = 3'd0,
        WSEQ_SUB  = 3'd1,
        WSEQ_AND  = 3'd2,
        WSEQ_OR   = 3'd3,
        WSEQ_XOR  = 3'd4,
        WSEQ_SLT  = 3'd5,
        WSEQ_SLTU = 3'd6,
        WSEQ_RSVD = 3'd7
    } wseq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wseq_state_t;

endpackage

// File: rtl/alu_word_seq_flags.sv
// Word-level flag and final-result formation from the assembled byte results.
// Purely combinational; the inputs are all registered in the top module, so the
// outputs are stable for as long as the response is held.
module alu_word_seq_flags #(
    parameter int W = 32
) (
    input  logic         a_msb,
    input  logic         b_eff_msb,
    input  logic         r_msb,
    input  logic         carry,
    input  logic [W-1:0] result,
    input  logic         legal,
    input  logic         is_arith,
    input  logic         is_slt,
    input  logic         is_sltu,
    output logic [W-1:0] out_result,
    output logic         out_carry,
    output logic         out_ovf,
    output logic         out_zero
);

    logic ovf_raw;

    // Select the final result and flags by operation class; zero follows the final result.
    always_comb begin
        ovf_raw    = (a_msb ~^ b_eff_msb) & (a_msb ^ r_msb);
        out_result = '0;
        out_carry  = 1'b0;
        out_ovf    = 1'b0;
        if (!legal) begin
            out_result = '0;
        end else if (is_slt) begin
            out_result = {{(W-1){1'b0}}, r_msb ^ ovf_raw};
        end else if (is_sltu) begin
            out_result = {{(W-1){1'b0}}, ~carry};
        end else begin
            out_result = result;
            out_carry  = is_arith & carry;
            out_ovf    = is_arith & ovf_raw;
        end
        out_zero = (out_result == '0);
    end

endmodule

// File: rtl/alu_word_seq.sv
// Word sequencer: accepts one multi-byte operation, drives the 8-bit alu one
// byte per cycle LSB first with chained carry, and returns the assembled word.
// Optional feature macro: ALU_WORD_SEQ_SLT_EN (adds SLT/SLTU, sequenced as SUB).
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; a held response keeps every resp_* output stable until resp_ready.
module alu_word_seq
    import alu_pkg::*;
    import alu_word_seq_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [8*WORD_BYTES-1:0] req_a,
    input  logic [8*WORD_BYTES-1:0] req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*WORD_BYTES-1:0] resp_result,
    output logic                    resp_carry,
    output logic                    resp_ovf,
    output logic                    resp_zero,
    output logic                    resp_illegal,
    output logic [7:0]              alu_operand_0,
    output logic [7:0]              alu_operand_1,
    output logic [2:0]              alu_operation,
    output logic                    alu_carry_in,
    output logic                    alu_invert_op_1,
    input  logic [7:0]              alu_result,
    input  logic                    alu_carry_out
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    wseq_state_t   state_q, state_d;
    wseq_op_t      op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;

    logic [2:0]    dec_alu_op;
    logic          dec_inv;
    logic          dec_cin0;
    logic          dec_legal;
    logic          dec_arith;
    logic          dec_is_slt;
    logic          dec_is_sltu;

    logic [W-1:0]  fl_result;
    logic          fl_carry;
    logic          fl_ovf;
    logic          fl_zero;

    // Decode the latched word op into alu controls and result-formation class.
    always_comb begin
        dec_alu_op  = ALU_OP_TEST;
        dec_inv     = 1'b0;
        dec_cin0    = 1'b0;
        dec_legal   = 1'b1;
        dec_arith   = 1'b0;
        dec_is_slt  = 1'b0;
        dec_is_sltu = 1'b0;
        case (op_q)
            WSEQ_ADD: begin
                dec_alu_op = ALU_OP_SUM;
                dec_arith  = 1'b1;
            end
            WSEQ_SUB: begin
                dec_alu_op = ALU_OP_SUM;
                dec_inv    = 1'b1;
                dec_cin0   = 1'b1;
                dec_arith  = 1'b1;
            end
            WSEQ_AND: dec_alu_op = ALU_OP_AND;
            WSEQ_OR:  dec_alu_op = ALU_OP_OR;
            WSEQ_XOR: dec_alu_op = ALU_OP_XOR;
`ifdef ALU_WORD_SEQ_SLT_EN
            WSEQ_SLT: begin
                dec_alu_op = ALU_OP_SUM;
                dec_inv    = 1'b1;
                dec_cin0   = 1'b1;
                dec_is_slt = 1'b1;
            end
            WSEQ_SLTU: begin
                dec_alu_op  = ALU_OP_SUM;
                dec_inv     = 1'b1;
                dec_cin0    = 1'b1;
                dec_is_sltu = 1'b1;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state, datapath updates and alu drive for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        res_d           = res_q;
        idx_d           = idx_q;
        carry_d         = carry_q;
        alu_operation   = ALU_OP_TEST;
        alu_operand_0   = 8'h00;
        alu_operand_1   = 8'h00;
        alu_carry_in    = 1'b0;
        alu_invert_op_1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RUN;
                    op_d    = wseq_op_t'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    res_d   = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ST_RUN: begin
                // An illegal op still takes the full slot but leaves the alu idle.
                if (dec_legal) begin
                    alu_operation   = dec_alu_op;
                    alu_operand_0   = a_q[8*idx_q +: 8];
                    alu_operand_1   = b_q[8*idx_q +: 8];
                    alu_invert_op_1 = dec_inv;
                    if (idx_q == '0) begin
                        alu_carry_in = dec_cin0;
                    end else if (dec_alu_op == ALU_OP_SUM) begin
                        alu_carry_in = carry_q;
                    end
                    res_d[8*idx_q +: 8] = alu_result;
                    carry_d             = alu_carry_out;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            op_q    <= WSEQ_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    alu_word_seq_flags #(
        .W (W)
    ) u_flags (
        .a_msb      (a_q[W-1]),
        .b_eff_msb  (b_q[W-1] ^ dec_inv),
        .r_msb      (res_q[W-1]),
        .carry      (carry_q),
        .result     (res_q),
        .legal      (dec_legal),
        .is_arith   (dec_arith),
        .is_slt     (dec_is_slt),
        .is_sltu    (dec_is_sltu),
        .out_result (fl_result),
        .out_carry  (fl_carry),
        .out_ovf    (fl_ovf),
        .out_zero   (fl_zero)
    );

    // Handshake and response outputs; everything is quiet outside DONE and while in reset.
    always_comb begin
        req_ready    = nrst & (state_q == ST_IDLE);
        resp_valid   = (state_q == ST_DONE);
        resp_result  = resp_valid ? fl_result : '0;
        resp_carry   = resp_valid & fl_carry;
        resp_ovf     = resp_valid & fl_ovf;
        resp_zero    = resp_valid & fl_zero;
        resp_illegal = resp_valid & ~dec_legal;
    end

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed bench for alu_word_seq with a behavioural byte alu attached.
module tb_alu_word_seq;
    import alu_pkg::*;

    localparam int WB = 4;
    localparam int W  = 8 * WB;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    logic         clk = 1'b0;
    logic         nrst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_carry;
    logic         resp_ovf;
    logic         resp_zero;
    logic         resp_illegal;
    logic [7:0]   alu_operand_0;
    logic [7:0]   alu_operand_1;
    logic [2:0]   alu_operation;
    logic         alu_carry_in;
    logic         alu_invert_op_1;
    logic [7:0]   alu_result;
    logic         alu_carry_out;

    int checks   = 0;
    int failures = 0;

    // clock and reset block
    always #5 clk = ~clk;

    alu_word_seq #(.WORD_BYTES(WB)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_result     (resp_result),
        .resp_carry      (resp_carry),
        .resp_ovf        (resp_ovf),
        .resp_zero       (resp_zero),
        .resp_illegal    (resp_illegal),
        .alu_operand_0   (alu_operand_0),
        .alu_operand_1   (alu_operand_1),
        .alu_operation   (alu_operation),
        .alu_carry_in    (alu_carry_in),
        .alu_invert_op_1 (alu_invert_op_1),
        .alu_result      (alu_result),
        .alu_carry_out   (alu_carry_out)
    );

    // behavioural 8-bit alu
    logic [7:0] m_bop;
    logic [8:0] m_sum;
    always_comb begin
        m_bop         = alu_invert_op_1 ? ~alu_operand_1 : alu_operand_1;
        m_sum         = {1'b0, alu_operand_0} + {1'b0, m_bop} + {8'h00, alu_carry_in};
        alu_result    = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_operation)
            ALU_OP_SUM: begin
                alu_result    = m_sum[7:0];
                alu_carry_out = m_sum[8];
            end
            ALU_OP_AND: alu_result = alu_operand_0 & m_bop;
            ALU_OP_OR:  alu_result = alu_operand_0 | m_bop;
            ALU_OP_XOR: alu_result = alu_operand_0 ^ m_bop;
            default: begin
                alu_result    = 8'h00;
                alu_carry_out = 1'b0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, ".req_ready"},    W'(req_ready), '0);
        check({tag, ".resp_valid"},   W'(resp_valid), '0);
        check({tag, ".resp_result"},  resp_result, '0);
        check({tag, ".resp_flags"},   W'({resp_carry, resp_ovf, resp_zero, resp_illegal}), '0);
        check({tag, ".alu_operands"}, W'({alu_operand_0, alu_operand_1}), '0);
        check({tag, ".alu_ctl"},      W'({alu_carry_in, alu_invert_op_1}), '0);
        check({tag, ".alu_operation"}, W'(alu_operation), W'(ALU_OP_TEST));
    endtask

    // driver: one full request/response transaction with optional response backpressure
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_c,
                          input logic exp_o, input logic exp_z, input logic exp_ill,
                          input int hold);
        int n;
        logic [W-1:0] held;
        @(negedge clk);
        check({name, ".req_ready_idle"}, W'(req_ready), W'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
        n = 1;
        check({name, ".byte0_operand_0"}, W'(alu_operand_0), exp_ill ? '0 : W'(a[7:0]));
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".latency"}, W'(n), W'(WB + 1));
        check({name, ".result"},  resp_result, exp_res);
        check({name, ".carry"},   W'(resp_carry), W'(exp_c));
        check({name, ".ovf"},     W'(resp_ovf), W'(exp_o));
        check({name, ".zero"},    W'(resp_zero), W'(exp_z));
        check({name, ".illegal"}, W'(resp_illegal), W'(exp_ill));
        held = resp_result;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_valid"},  W'(resp_valid), W'(1));
            check({name, ".hold_result"}, resp_result, exp_res);
            check({name, ".hold_flags"},  W'({resp_carry, resp_ovf, resp_zero}), W'({exp_c, exp_o, exp_z}));
            check({name, ".hold_ready"},  W'(req_ready), '0);
        end
        check({name, ".held_stable"}, resp_result, held);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({name, ".post_valid"}, W'(resp_valid), '0);
        check({name, ".post_ready"}, W'(req_ready), W'(1));
    endtask

    initial begin
        logic seen;
        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;

        // idle with no request and stray resp_ready: nothing happens
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("idle.resp_valid", W'(resp_valid), '0);
        check("idle.req_ready",  W'(req_ready), W'(1));

        run_op("add_ff_1",   OP_ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub_min_1",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        run_op("sub_5_5",    OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_op("add_wrap",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_op("add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_op("xor",        OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("or",         OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // reset pulse while byte 2 is on the alu aborts the operation
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 32'h1111_1111;
        req_b     = 32'h2222_2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort.byte2_operand_0", W'(alu_operand_0), W'(8'h11));
        nrst = 1'b0;
        #1;
        check_quiet_outputs("abort");
        @(negedge clk);
        nrst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | resp_valid;
        end
        check("abort.no_response", W'(seen), '0);

        run_op("and_after_rst", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 32'h00F0_F0F0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("rsvd",          OP_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
`ifdef ALU_WORD_SEQ_SLT_EN
        run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
`else
        run_op("op5_illegal", OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        run_op("op6_illegal", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
`endif

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
